id_ex_reg: RTL and testbench

ID/EX pipeline register for the five-stage MIPS datapath. Captures the decode-stage control word, after the hazard control-zeroing mux, together with the operand data, immediate, funct and register addresses. Presents them registered to the EX stage, forwarding unit and hazard detection unit. Supports stall (hold), flush (bubble) and a per-entry valid bit, plus an optional bubble counter for CPI analysis.

---
 rtl/id_ex_reg.sv | 167 ++++++++++++++++
 tb/tb_id_ex_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the five-stage MIPS datapath.
// Holds the decode-stage control word and operand data for the EX stage,
// forwarding unit and hazard detection unit. It supports stall (hold),
// flush/hazard (bubble) and a per-entry valid bit.
// Optional feature: define IDEX_BUBBLE_CNT_EN to add the bubble_cnt_o port
// and a wrapping counter of inserted bubbles.
module id_ex_reg #(
    parameter int DATA_W = 32
`ifdef IDEX_BUBBLE_CNT_EN
    , parameter int CNT_W  = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              hazard_i,
    input  logic              valid_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic              MemWr_i,
    input  logic              MemRd_i,
    input  logic              MemtoReg_i,
    input  logic              RegWr_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] RS_data_i,
    input  logic [DATA_W-1:0] RT_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [5:0]        funct_i,
    input  logic [4:0]        RS_addr_i,
    input  logic [4:0]        RT_addr_i,
    input  logic [4:0]        RD_addr_i,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic              MemWr_o,
    output logic              MemRd_o,
    output logic              MemtoReg_o,
    output logic              RegWr_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] RS_data_o,
    output logic [DATA_W-1:0] RT_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [5:0]        funct_o,
    output logic [4:0]        RS_addr_o,
    output logic [4:0]        RT_addr_o,
    output logic [4:0]        RD_addr_o,
    output logic              valid_o
`ifdef IDEX_BUBBLE_CNT_EN
    , output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

    // Control word: everything that must be zero in a bubble.
    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       mem_wr;
        logic       mem_rd;
        logic       mem_to_reg;
        logic       reg_wr;
        logic [1:0] alu_op;
    } ctrl_t;

    // Payload: loaded whenever not stalled, contents irrelevant in a bubble.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [5:0]        funct;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        rd_addr;
    } data_t;

    ctrl_t ctrl_d, ctrl_q;
    data_t data_d, data_q;
    logic  valid_q;
    logic  keep_ctrl;

    assign ctrl_d = '{alu_src:    ALUSrc_i,
                      reg_dst:    RegDst_i,
                      mem_wr:     MemWr_i,
                      mem_rd:     MemRd_i,
                      mem_to_reg: MemtoReg_i,
                      reg_wr:     RegWr_i,
                      alu_op:     ALUOp_i};

    assign data_d = '{pc:      pc_i,
                      rs_data: RS_data_i,
                      rt_data: RT_data_i,
                      imm:     imm_i,
                      funct:   funct_i,
                      rs_addr: RS_addr_i,
                      rt_addr: RT_addr_i,
                      rd_addr: RD_addr_i};

    // A load keeps its controls only for a real instruction with no load-use
    // hazard; zeroing them together with valid keeps the "bubble never
    // writes state" invariant local to this register.
    assign keep_ctrl = valid_i & ~hazard_i;

    // Control and valid: reset > flush > stall (hold) > hazard/normal load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            ctrl_q  <= keep_ctrl ? ctrl_d : '0;
            valid_q <= keep_ctrl;
        end
    end

    // Payload: cleared on reset, otherwise loads unless stalled (a flush
    // under stall therefore holds the old payload, which stays deterministic).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (!stall_i) begin
            data_q <= data_d;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic             bubble_ev;
    logic [CNT_W-1:0] bubble_cnt_q;

    // A bubble replaces the entry on a flush, or on a hazard that is not
    // masked by a stall; flush+hazard together is still a single bubble.
    assign bubble_ev = flush_i | (hazard_i & ~stall_i);

    // Free-running wrap-around bubble counter for CPI analysis.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else if (bubble_ev) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

    assign ALUSrc_o   = ctrl_q.alu_src;
    assign RegDst_o   = ctrl_q.reg_dst;
    assign MemWr_o    = ctrl_q.mem_wr;
    assign MemRd_o    = ctrl_q.mem_rd;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign RegWr_o    = ctrl_q.reg_wr;
    assign ALUOp_o    = ctrl_q.alu_op;
    assign valid_o    = valid_q;

    assign pc_o       = data_q.pc;
    assign RS_data_o  = data_q.rs_data;
    assign RT_data_o  = data_q.rt_data;
    assign imm_o      = data_q.imm;
    assign funct_o    = data_q.funct;
    assign RS_addr_o  = data_q.rs_addr;
    assign RT_addr_o  = data_q.rt_addr;
    assign RD_addr_o  = data_q.rd_addr;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a vector table plus hand sequences,
// with expectations queued at drive time and popped after the clock edge.
module tb_id_ex_reg;

    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [5:0]  funct;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
    } dat_t;

    // ctrl bit order: ALUSrc RegDst MemWr MemRd MemtoReg RegWr ALUOp[1:0]
    typedef struct {
        logic       rst, stall, flush, hazard, valid;
        logic [7:0] ctrl;
        logic [7:0] e_ctrl;
        logic       e_valid;
        int         e_src;   // -1: zero payload, -2: payload not checked
        int         e_cnt;
    } vec_t;

    typedef struct {
        string        name;
        logic [157:0] exp;
        logic [157:0] mask;
        int           cnt;
    } sb_t;

    logic clk = 1'b0;
    logic rst, stall, flush, hazard, valid;
    logic alusrc, regdst, memwr, memrd, memtoreg, regwr;
    logic [1:0] aluop;
    logic [DW-1:0] pc, rsd, rtd, imm;
    logic [5:0] funct;
    logic [4:0] rsa, rta, rda;

    logic alusrc_o, regdst_o, memwr_o, memrd_o, memtoreg_o, regwr_o, valid_o;
    logic [1:0] aluop_o;
    logic [DW-1:0] pc_o, rsd_o, rtd_o, imm_o;
    logic [5:0] funct_o;
    logic [4:0] rsa_o, rta_o, rda_o;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [3:0] cnt_o;
`endif

    int total = 0;
    int bad = 0;
    sb_t sbq[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    id_ex_reg #(
        .DATA_W(DW)
`ifdef IDEX_BUBBLE_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .hazard_i(hazard), .valid_i(valid),
        .ALUSrc_i(alusrc), .RegDst_i(regdst), .MemWr_i(memwr), .MemRd_i(memrd),
        .MemtoReg_i(memtoreg), .RegWr_i(regwr), .ALUOp_i(aluop),
        .pc_i(pc), .RS_data_i(rsd), .RT_data_i(rtd), .imm_i(imm), .funct_i(funct),
        .RS_addr_i(rsa), .RT_addr_i(rta), .RD_addr_i(rda),
        .ALUSrc_o(alusrc_o), .RegDst_o(regdst_o), .MemWr_o(memwr_o), .MemRd_o(memrd_o),
        .MemtoReg_o(memtoreg_o), .RegWr_o(regwr_o), .ALUOp_o(aluop_o),
        .pc_o(pc_o), .RS_data_o(rsd_o), .RT_data_o(rtd_o), .imm_o(imm_o), .funct_o(funct_o),
        .RS_addr_o(rsa_o), .RT_addr_o(rta_o), .RD_addr_o(rda_o),
        .valid_o(valid_o)
`ifdef IDEX_BUBBLE_CNT_EN
        , .bubble_cnt_o(cnt_o)
`endif
    );

    function automatic dat_t data_of(input int k);
        dat_t d;
        d.pc    = 32'h0040_0000 + 32'(k) * 4;
        d.rs    = {16'hAA00, 16'(k)};
        d.rt    = {16'hBB00, 16'(k)};
        d.imm   = {16'hCC00, 16'(k)};
        d.funct = 6'(k) ^ 6'h15;
        d.rsa   = 5'(k);
        d.rta   = ~5'(k);
        d.rda   = 5'(k) + 5'd3;
        return d;
    endfunction

    function automatic vec_t mk(input logic r, s, f, h, v, input logic [7:0] c,
                                input logic [7:0] ec, input logic ev, input int src,
                                input int ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.hazard = h; t.valid = v; t.ctrl = c;
        t.e_ctrl = ec; t.e_valid = ev; t.e_src = src; t.e_cnt = ecnt;
        return t;
    endfunction

    // Drive one cycle, queue its expectation, then pop and compare after the edge.
    task automatic step(input string nm, input logic r, s, f, h, v,
                        input logic [7:0] c, input dat_t d,
                        input logic [7:0] ec, input logic ev, input dat_t ed,
                        input logic chk_d, input int ecnt);
        sb_t e, got;
        logic [157:0] act;
        @(negedge clk);
        rst = r; stall = s; flush = f; hazard = h; valid = v;
        {alusrc, regdst, memwr, memrd, memtoreg, regwr, aluop} = c;
        pc = d.pc; rsd = d.rs; rtd = d.rt; imm = d.imm; funct = d.funct;
        rsa = d.rsa; rta = d.rta; rda = d.rda;
        e.name = nm;
        e.exp  = {ec, ev, ed};
        e.mask = chk_d ? {158{1'b1}} : {{9{1'b1}}, 149'b0};
        e.cnt  = ecnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        act = {alusrc_o, regdst_o, memwr_o, memrd_o, memtoreg_o, regwr_o, aluop_o,
               valid_o, pc_o, rsd_o, rtd_o, imm_o, funct_o, rsa_o, rta_o, rda_o};
        total++;
        if ((act & got.mask) !== (got.exp & got.mask)) begin
            bad++;
            $display("FAIL %s outputs act=%h exp=%h", got.name, act & got.mask, got.exp & got.mask);
        end
        // invariant: a non-valid entry never writes state
        total++;
        if (!valid_o && (regwr_o || memwr_o || memrd_o)) begin
            bad++;
            $display("FAIL %s invariant act=%b%b%b exp=000", got.name, regwr_o, memwr_o, memrd_o);
        end
`ifdef IDEX_BUBBLE_CNT_EN
        if (got.cnt >= 0) begin
            total++;
            if (cnt_o !== 4'(got.cnt)) begin
                bad++;
                $display("FAIL %s bubble_cnt act=%0d exp=%0d", got.name, cnt_o, got.cnt);
            end
        end
`endif
    endtask

    initial begin
        dat_t z, a, b, ed;
        z = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; hazard = 1'b0; valid = 1'b0;
        {alusrc, regdst, memwr, memrd, memtoreg, regwr, aluop} = 8'h00;
        pc = '0; rsd = '0; rtd = '0; imm = '0; funct = '0; rsa = '0; rta = '0; rda = '0;

        //            rst stall flush haz valid ctrl   e_ctrl e_v src cnt
        tbl[0]  = mk(1, 1, 1, 1, 1, 8'hFF, 8'h00, 0, -1, 0);
        tbl[1]  = mk(1, 0, 1, 0, 1, 8'hFF, 8'h00, 0, -1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 8'hA6, 8'hA6, 1,  2, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 8'h59, 8'h59, 1,  3, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0,  4, 0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 8'h12, 8'h00, 0,  4, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 8'h3C, 8'h3C, 1,  6, 0);
        tbl[7]  = mk(0, 1, 0, 1, 1, 8'h11, 8'h3C, 1,  6, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, 8'h10, 8'h00, 0,  8, 1);
        tbl[9]  = mk(0, 0, 1, 0, 1, 8'hFF, 8'h00, 0, -2, 2);
        tbl[10] = mk(0, 0, 0, 0, 1, 8'h24, 8'h24, 1, 10, 2);
        tbl[11] = mk(0, 1, 1, 0, 1, 8'hFF, 8'h00, 0, 10, 3);
        tbl[12] = mk(0, 0, 1, 1, 1, 8'hFF, 8'h00, 0, -2, 4);
        tbl[13] = mk(0, 0, 0, 0, 1, 8'hE7, 8'hE7, 1, 13, 4);
        tbl[14] = mk(1, 1, 1, 0, 1, 8'hFF, 8'h00, 0, -1, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 8'hC3, 8'hC3, 1, 15, 0);

        for (int i = 0; i < 16; i++) begin
            ed = (tbl[i].e_src >= 0) ? data_of(tbl[i].e_src) : z;
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].stall, tbl[i].flush,
                 tbl[i].hazard, tbl[i].valid, tbl[i].ctrl, data_of(i),
                 tbl[i].e_ctrl, tbl[i].e_valid, ed, tbl[i].e_src != -2, tbl[i].e_cnt);
        end

        // reset with all inputs nonzero, then normal flow with exact values
        step("rst_a", 1, 0, 0, 0, 1, 8'hFF, data_of(99), 8'h00, 0, z, 1, 0);
        step("rst_b", 1, 0, 0, 0, 1, 8'hFF, data_of(98), 8'h00, 0, z, 1, 0);
        a = z; a.rs = 32'h0000_00AA; a.rda = 5'd8;
        step("normal", 0, 0, 0, 0, 1, 8'h06, a, 8'h06, 1, a, 1, 0);

        // stall hold: A stays for three stalled cycles, B loads after
        a = data_of(40); a.rt = 32'h1234_5678;
        b = data_of(41); b.rt = 32'h8765_4321;
        step("stall_ld_a", 0, 0, 0, 0, 1, 8'h8E, a, 8'h8E, 1, a, 1, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_hold%0d", i), 0, 1, 0, 0, 1, 8'h31, b, 8'h8E, 1, a, 1, 0);
        step("stall_ld_b", 0, 0, 0, 0, 1, 8'h31, b, 8'h31, 1, b, 1, 0);

        // load-use bubble
        step("loaduse", 0, 0, 0, 1, 1, 8'h10, data_of(50), 8'h00, 0, data_of(50), 1, 1);

        // flush over stall, then stall+hazard hold
        step("memwr_ld", 0, 0, 0, 0, 1, 8'h20, data_of(51), 8'h20, 1, data_of(51), 1, 1);
        step("flush_stall", 0, 1, 1, 0, 1, 8'h20, data_of(52), 8'h00, 0, data_of(51), 1, 2);
        step("stall_haz", 0, 1, 0, 1, 1, 8'h20, data_of(53), 8'h00, 0, data_of(51), 1, 2);

`ifdef IDEX_BUBBLE_CNT_EN
        // counter wrap at CNT_W = 4
        step("wrap_rst", 1, 0, 0, 0, 0, 8'h00, z, 8'h00, 0, z, 1, 0);
        for (int i = 1; i <= 17; i++)
            step($sformatf("wrap%0d", i), 0, 0, 1, 0, 1, 8'hFF, data_of(i), 8'h00, 0, z, 0,
                 (i >= 15) ? (i % 16) : -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
